// File: rtl/lsu_pkg.sv
// Shared types and helpers for the pako32 load/store unit: access sizes,
// FSM states, and the byte-lane write/extend functions.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  // The fifo_if register window spans 16 bytes.
  localparam int MMIO_AW = 4;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << {off[1], 1'b0};
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Store data arrives in lane 0; replicate it so every enabled lane sees it.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    return {4{data[7:0]}};
      SZ_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (size)
      SZ_B:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_data.sv
// Single-port data RAM, 32-bit words with per-byte write enables and a
// registered read port that returns the word as it was before the write.
module mem_data #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  // One byte-wide array per lane keeps each lane a simple inferable RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [WORDS];
    logic [7:0] r_q;

    always_ff @(posedge clk_i) begin
      if (en_i) begin
        r_q <= r_mem[addr_i];
        if (be_i[gi]) r_mem[addr_i] <= wdata_i[gi*8 +: 8];
      end
    end

    assign rdata_o[gi*8 +: 8] = r_q;
  end

endmodule

// File: rtl/lsu.sv
// pako32 load/store unit: decodes ALU addresses into data RAM or the fifo_if
// window, runs a three-cycle access (two on error) and returns extended load data.
module lsu
  import lsu_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hF000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        fifo_sel_o,
  output logic        fifo_rd_o,
  output logic        fifo_wr_o,
  output logic [1:0]  fifo_addr_o,
  output logic [7:0]  fifo_wrdata_o,
  input  logic [7:0]  fifo_rddata_i
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t        r_state, w_state_next;
  logic          w_accept, w_is_mmio, w_is_ram, w_misal, w_err, w_mmio_go;

  logic          r_req_we, r_req_uns, r_req_mmio;
  logic [1:0]    r_req_size, r_req_off;
  logic [AW-1:0] r_req_widx;
  logic [31:0]   r_req_wdata;

  logic          r_rsp_valid, r_rsp_err;
  logic          r_fifo_sel, r_fifo_rd, r_fifo_wr;
  logic [1:0]    r_fifo_addr;
  logic [7:0]    r_fifo_wrdata;

  logic          w_mem_en;
  logic [3:0]    w_mem_be;
  logic [31:0]   w_mem_wdata, w_mem_rdata, w_rdata;

  assign w_is_mmio = req_addr_i[31:MMIO_AW] == MMIO_BASE[31:MMIO_AW];
  assign w_is_ram  = {2'b00, req_addr_i[31:2]} < 32'(MEM_WORDS);

  // The fifo_if window is word-addressed only, whatever the access size.
  always_comb begin
    w_misal = 1'b0;
    if (w_is_mmio) begin
      w_misal = req_addr_i[1:0] != 2'b00;
    end else begin
      case (req_size_i)
        SZ_H:    w_misal = req_addr_i[0];
        SZ_W:    w_misal = req_addr_i[1:0] != 2'b00;
        default: w_misal = 1'b0;
      endcase
    end
  end

  assign w_err     = (req_size_i == 2'd3) || w_misal || !(w_is_mmio || w_is_ram);
  assign w_accept  = (r_state == IDLE) && req_valid_i;
  assign w_mmio_go = w_accept && !w_err && w_is_mmio;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_valid_i) w_state_next = w_err ? ERR : ACC;
      ACC:     w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      ERR:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_fifo_sel    <= 1'b0;
      r_fifo_rd     <= 1'b0;
      r_fifo_wr     <= 1'b0;
      r_fifo_addr   <= '0;
      r_fifo_wrdata <= '0;
    end else begin
      r_state       <= w_state_next;
      r_rsp_valid   <= (w_state_next == RESP) || (w_state_next == ERR);
      r_rsp_err     <= w_state_next == ERR;
      r_fifo_sel    <= w_mmio_go;
      r_fifo_rd     <= w_mmio_go && !req_we_i;
      r_fifo_wr     <= w_mmio_go && req_we_i;
      r_fifo_addr   <= w_mmio_go ? req_addr_i[3:2] : 2'b00;
      r_fifo_wrdata <= w_mmio_go ? req_wdata_i[7:0] : 8'h00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_req_we    <= req_we_i;
      r_req_uns   <= req_unsigned_i;
      r_req_mmio  <= w_is_mmio;
      r_req_size  <= req_size_i;
      r_req_off   <= req_addr_i[1:0];
      r_req_widx  <= req_addr_i[AW+1:2];
      r_req_wdata <= req_wdata_i;
    end
  end

  // A reset landing on the ACC edge aborts the access, including its RAM write.
  assign w_mem_en    = (r_state == ACC) && !r_req_mmio && !rst_i;
  assign w_mem_be    = r_req_we ? byte_en(r_req_size, r_req_off) : 4'b0000;
  assign w_mem_wdata = store_lanes(r_req_size, r_req_wdata);

  mem_data #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .en_i    (w_mem_en),
    .be_i    (w_mem_be),
    .addr_i  (r_req_widx),
    .wdata_i (w_mem_wdata),
    .rdata_o (w_mem_rdata)
  );

  always_comb begin
    w_rdata = '0;
    if (r_state == RESP && !r_req_we) begin
      w_rdata = r_req_mmio ? {24'b0, fifo_rddata_i}
                           : load_extend(w_mem_rdata, r_req_size, r_req_off, r_req_uns);
    end
  end

  assign req_ready_o   = r_state == IDLE;
  assign busy_o        = r_state != IDLE;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_rdata_o   = w_rdata;
  assign fifo_sel_o    = r_fifo_sel;
  assign fifo_rd_o     = r_fifo_rd;
  assign fifo_wr_o     = r_fifo_wr;
  assign fifo_addr_o   = r_fifo_addr;
  assign fifo_wrdata_o = r_fifo_wrdata;

endmodule

// File: tb/tb_lsu.sv
// Randomised bench for lsu against a byte-array reference model of the RAM
// and the fifo_if window; one line per transaction.
module tb_lsu;

  localparam int          MEM_WORDS = 1024;
  localparam int          BYTES     = MEM_WORDS * 4;
  localparam logic [31:0] MMIO_BASE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        fifo_sel_o, fifo_rd_o, fifo_wr_o;
  logic [1:0]  fifo_addr_o;
  logic [7:0]  fifo_wrdata_o;
  logic [7:0]  fifo_rddata_i = 8'h00;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [BYTES];

  always #5 clk = ~clk;

  lsu #(
    .MEM_WORDS (MEM_WORDS),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .busy_o         (busy_o),
    .fifo_sel_o     (fifo_sel_o),
    .fifo_rd_o      (fifo_rd_o),
    .fifo_wr_o      (fifo_wr_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_wrdata_o  (fifo_wrdata_o),
    .fifo_rddata_i  (fifo_rddata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full access: the model predicts error/data/strobes, then the DUT is
  // sampled at each negedge for four cycles after acceptance.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [7:0] rdv, output logic [31:0] rdata);
    logic        is_ram, is_mmio, exp_err, exp_strb;
    logic [31:0] exp_rdata, got_rdata;
    logic        got_err, s_rd, s_wr;
    logic [1:0]  s_addr;
    logic [7:0]  s_wd;
    logic [11:0] ba;
    int          nb, got_cyc, rsp_cnt, strb_cnt, strb_cyc;

    nb      = 1 << size;
    is_ram  = addr < 32'(BYTES);
    is_mmio = (addr & 32'hFFFF_FFF0) == MMIO_BASE;
    exp_err = (size == 2'd3) || !(is_ram || is_mmio) ||
              (is_mmio && addr[1:0] != 2'b00) ||
              (is_ram && (int'(addr[1:0]) % nb) != 0);
    exp_strb  = is_mmio && !exp_err;
    exp_rdata = 32'h0;
    if (!exp_err && !we) begin
      if (is_mmio) begin
        exp_rdata = {24'h0, rdv};
      end else begin
        for (int i = 0; i < nb; i++) begin
          ba = 12'(addr + 32'(i));
          exp_rdata = exp_rdata | (32'(ref_mem[ba]) << (8 * i));
        end
        if (!uns && nb < 4 && exp_rdata[8*nb-1]) exp_rdata = exp_rdata | (32'hFFFF_FFFF << (8 * nb));
      end
    end

    @(negedge clk);
    check("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_we_i    = 1'($urandom);

    got_cyc = 0; rsp_cnt = 0; strb_cnt = 0; strb_cyc = 0;
    got_err = 1'b0; got_rdata = 32'h0;
    s_rd = 1'b0; s_wr = 1'b0; s_addr = 2'b00; s_wd = 8'h00;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      fifo_rddata_i = (c == 2) ? rdv : ~rdv;
      @(negedge clk);
      if (c == 1) begin
        check("ready_busy_c1", {30'h0, req_ready_o, busy_o}, 32'd1);
      end
      if (fifo_sel_o || fifo_rd_o || fifo_wr_o) begin
        strb_cnt++;
        strb_cyc = c;
        s_rd = fifo_rd_o; s_wr = fifo_wr_o; s_addr = fifo_addr_o; s_wd = fifo_wrdata_o;
        check("fifo_sel", 32'(fifo_sel_o), 32'd1);
      end
      if (rsp_valid_o) begin
        rsp_cnt++;
        if (got_cyc == 0) begin
          got_cyc = c; got_err = rsp_err_o; got_rdata = rsp_rdata_o;
        end
      end else begin
        check("quiet_rsp", {rsp_err_o, rsp_rdata_o[30:0]} | {31'h0, rsp_rdata_o[31]}, 32'h0);
      end
    end

    check("rsp_cnt", 32'(rsp_cnt), 32'd1);
    check("latency", 32'(got_cyc), exp_err ? 32'd1 : 32'd2);
    check("err", 32'(got_err), 32'(exp_err));
    check("rdata", got_rdata, exp_rdata);
    check("strobe_cnt", 32'(strb_cnt), 32'(exp_strb));
    if (exp_strb) begin
      check("strobe_cyc", 32'(strb_cyc), 32'd1);
      check("fifo_rdwr", {30'h0, s_rd, s_wr}, {30'h0, !we, we});
      check("fifo_addr", 32'(s_addr), 32'(addr[3:2]));
      if (we) check("fifo_wrdata", 32'(s_wd), 32'(wdata[7:0]));
    end

    if (!exp_err && we && is_ram) begin
      for (int i = 0; i < nb; i++) begin
        ba = 12'(addr + 32'(i));
        ref_mem[ba] = 8'(wdata >> (8 * i));
      end
    end
    rdata = got_rdata;
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h -> err=%0d rdata=%h (exp err=%0d rdata=%h)",
             we, size, uns, addr, wdata, got_err, got_rdata, exp_err, exp_rdata);
  endtask

  task automatic reset_abort(input logic [31:0] addr);
    int vcnt;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd2; req_unsigned_i = 1'b0;
    req_addr_i = addr; req_wdata_i = 32'hA5A5_5A5A;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid_o) vcnt++;
      if (c == 0) begin
        check("rst_ready_busy", {30'h0, req_ready_o, busy_o}, 32'd2);
        check("rst_fifo", {29'h0, fifo_sel_o, fifo_rd_o, fifo_wr_o}, 32'd0);
      end
    end
    check("rst_no_rsp", 32'(vcnt), 32'd0);
    $display("txn reset-abort store addr=%h rsp_pulses=%0d", addr, vcnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, addr;
    logic [1:0]  size;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready_busy", {30'h0, req_ready_o, busy_o}, 32'd2);
    check("reset_rsp", {31'h0, rsp_valid_o | rsp_err_o}, 32'd0);
    check("reset_rdata", rsp_rdata_o, 32'd0);
    check("reset_fifo", {19'h0, fifo_sel_o, fifo_rd_o, fifo_wr_o, fifo_addr_o, fifo_wrdata_o}, 32'd0);
    rst_i = 1'b0;
    $display("txn reset released");

    for (int w = 0; w < 32; w++) access(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 8'h00, rd);
    for (int w = MEM_WORDS - 4; w < MEM_WORDS; w++) access(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 8'h00, rd);

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 8'h00, rd);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 8'h00, rd);
    check("plan_word", rd, 32'hDEAD_BEEF);
    access(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, 8'h00, rd);
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 8'h00, rd);
    check("plan_sbyte", rd, 32'hFFFF_FF80);
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 8'h00, rd);
    check("plan_ubyte", rd, 32'h0000_0080);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 8'h00, rd);
    check("plan_merged", rd, 32'h80AD_BEEF);
    access(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 8'h00, rd);
    access(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 8'h00, rd);
    access(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 8'h00, rd);
    access(1'b1, 2'd2, 1'b0, MMIO_BASE + 32'd8, 32'h1234_5641, 8'h00, rd);
    access(1'b0, 2'd2, 1'b0, MMIO_BASE + 32'd4, 32'h0, 8'h9C, rd);
    check("plan_mmio_rd", rd, 32'h0000_009C);
    access(1'b0, 2'd2, 1'b0, 32'(BYTES), 32'h0, 8'h00, rd);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 8'h00, rd);
    check("plan_ram_kept", rd, 32'h80AD_BEEF);

    reset_abort(32'h20);
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 8'h00, rd);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: addr = 32'($urandom_range(0, 127));
        5, 6:          addr = 32'($urandom_range(BYTES - 16, BYTES - 1));
        7, 8:          addr = MMIO_BASE + 32'($urandom_range(0, 15));
        default: begin
          case ($urandom_range(0, 2))
            0:       addr = 32'(BYTES) + 32'($urandom_range(0, 1000));
            1:       addr = MMIO_BASE + 32'd16 + 32'($urandom_range(0, 64));
            default: addr = MMIO_BASE - 32'd4;
          endcase
        end
      endcase
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      access(1'($urandom), size, 1'($urandom), addr, $urandom, 8'($urandom), rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
